mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage placed directly downstream of the ALU stage in the execution unit. It takes the ALU result as the effective address and performs one load or store per accepted operation through a request/response handshake with data RAM. Byte and halfword lanes are aligned here, and loads are sign- or zero-extended. It emits a single-cycle writeback beat for loads, which feeds the register-store path.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for a RAM response before the access is abandoned; range 1..255.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- op_valid  in  1  an operation is offered.
- op_ready  out  1  the stage can accept an operation; high only in IDLE.
- op_is_store  in  1  1 = store, 0 = load.
- op_size  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is illegal and treated as misaligned.
- op_unsigned  in  1  zero-extend the load when set.
- op_addr  in  32  effective address (the ALU result).
- op_store_data  in  32  store source (rs2 value).
- op_rd  in  5  load destination register.
- rd_ram_en  out  1  read request; held until the response arrives.
- rd_ram_addr  out  32  word-aligned read address.
- rd_ram_data  in  32  read data; valid when rd_ram_valid is high.
- rd_ram_valid  in  1  read response strobe.
- wr_ram_en  out  1  write request; held until acknowledged.
- wr_ram_addr  out  32  word-aligned write address.
- wr_ram_data  out  32  lane-replicated write data.
- wr_ram_mask  out  4  byte-enable mask; bit i enables byte i.
- wr_ram_ack  in  1  write acknowledge strobe.
- wb_valid  out  1  one-cycle load writeback beat.
- wb_rd  out  5  writeback destination register.
- wb_data  out  32  extended load data.
- misaligned  out  1  one-cycle error pulse.
- timeout  out  1  one-cycle error pulse.

## Operation
- FSM states: IDLE, LOAD_WAIT, STORE_WAIT, RESP.
- Accept: an operation is accepted on op_valid & op_ready; all op_* inputs are latched at that edge.
- Misalignment check at accept: half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Pulse misaligned for one cycle.
  - Stay in IDLE; issue no RAM request and no writeback.
- Load path (IDLE → LOAD_WAIT):
  - Drive rd_ram_en=1 and rd_ram_addr={addr[31:2],2'b00}.
  - On rd_ram_valid: select the lane by addr[1:0] (byte) or addr[1] (half), extend per op_unsigned, and register wb_data and wb_rd.
  - Drop rd_ram_en and go to RESP.
- RESP: wb_valid=1 for exactly one cycle (forced 0 when rd=0), then IDLE.
- Store path (IDLE → STORE_WAIT):
  - wr_ram_data is the byte replicated ×4, the half replicated ×2, or the word as-is.
  - wr_ram_mask is 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a half, 1111 for a word.
  - On wr_ram_ack: drop wr_ram_en and go to IDLE. A store produces no writeback.
- Timeout:
  - A wait counter clears on entry to either wait state and increments each cycle without a response.
  - When it reaches TIMEOUT_CYCLES: drop the enable, pulse timeout, go to IDLE, and produce no writeback.
  - A response arriving in the same cycle the limit is reached wins; timeout is not pulsed.
- Stray strobes: rd_ram_valid or wr_ram_ack seen outside the matching wait state are ignored.

## Timing
- Reset values: every output is 0 except op_ready, which is 1; state is IDLE; the counter is 0.
- Reset mid-operation: enables drop asynchronously and no wb_valid or error pulse follows.
- Request outputs are registered, asserted from cycle T+1 after an accept at edge T.
- Load with response at T+1: wb_valid at T+2, op_ready high again at T+3. Minimum load occupancy is 3 cycles.
- Store with ack at T+1: op_ready high at T+2.
- misaligned is high during cycle T+1; op_ready remains high, so back-to-back accepts are allowed.
- RAM address, data and mask are stable for the whole time their enable is high.

## Structure
- Package mem_stage_pkg holds:
  - mem_size_t enum (BYTE, HALF, WORD).
  - mem_state_t enum (IDLE, LOAD_WAIT, STORE_WAIT, RESP).
  - Function is_misaligned(size, addr[1:0]).
- Sub-module mem_lane_align (combinational) performs store replicate/mask and load extract/extend; it is instantiated once.
- The FSM, wait counter and output registers live in mem_access_stage.

## Test plan
- Load byte signed, addr 0x103, RAM word 0x80FF_1234, valid one cycle after rd_ram_en → rd_ram_addr 0x100, wb_data 0xFFFF_FF80, wb_rd as issued, wb_valid for 1 cycle.
- Load half unsigned, addr 0x22, RAM word 0xBEEF_0001 → wb_data 0x0000_BEEF; the same load with rd=0 → wb_valid stays 0.
- Store byte 0x...A5 to addr 0x41 → wr_ram_addr 0x40, wr_ram_data 0xA5A5_A5A5, wr_ram_mask 0010; ack after 3 cycles → op_ready returns the cycle after ack.
- Word load at 0x6 → misaligned pulse, rd_ram_en never asserted; a valid load on the next cycle is accepted normally.
- TIMEOUT_CYCLES=4 with no response → timeout pulse, enable dropped, IDLE, no wb. With valid arriving exactly at count 4 → normal writeback and no timeout.
- reset_n low during LOAD_WAIT → rd_ram_en drops immediately; after release, op_ready=1, and a later rd_ram_valid produces nothing.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage: access sizes,
// FSM states and the alignment check applied when an operation is accepted.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LOAD_WAIT  = 2'b01,
    STORE_WAIT = 2'b10,
    RESP       = 2'b11
  } mem_state_t;

  // Size 2'b11 has no legal encoding, so it is reported as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Operation, data-RAM and writeback signals of the memory-access stage.
// slave is the stage's view; master is the view of the surrounding pipeline and RAM.
interface mem_access_stage_if;
  logic        op_valid;
  logic        op_ready;
  logic        op_is_store;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic [31:0] op_addr;
  logic [31:0] op_store_data;
  logic [4:0]  op_rd;

  logic        rd_ram_en;
  logic [31:0] rd_ram_addr;
  logic [31:0] rd_ram_data;
  logic        rd_ram_valid;

  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [3:0]  wr_ram_mask;
  logic        wr_ram_ack;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned;
  logic        timeout;

  modport slave (
    input  op_valid, op_is_store, op_size, op_unsigned, op_addr, op_store_data, op_rd,
    input  rd_ram_data, rd_ram_valid, wr_ram_ack,
    output op_ready, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_mask,
    output wb_valid, wb_rd, wb_data, misaligned, timeout
  );

  modport master (
    output op_valid, op_is_store, op_size, op_unsigned, op_addr, op_store_data, op_rd,
    output rd_ram_data, rd_ram_valid, wr_ram_ack,
    input  op_ready, rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_mask,
    input  wb_valid, wb_rd, wb_data, misaligned, timeout
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data replication and byte mask, and load lane
// extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] wr_data_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_data_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rd_data_i[15:8];
      2'd2:    byte_sel = rd_data_i[23:16];
      2'd3:    byte_sel = rd_data_i[31:24];
      default: byte_sel = rd_data_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
  end

  always_comb begin
    wr_data_o = st_data_i;
    wr_mask_o = 4'b1111;
    ld_data_o = rd_data_i;
    case (size_i)
      BYTE: begin
        wr_data_o = {4{st_data_i[7:0]}};
        wr_mask_o = 4'b0001 << addr_lo_i;
        ld_data_o = unsigned_i ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        wr_data_o = {2{st_data_i[15:0]}};
        wr_mask_o = 4'b0011 << addr_lo_i;
        ld_data_o = unsigned_i ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        wr_data_o = st_data_i;
        wr_mask_o = 4'b1111;
        ld_data_o = rd_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one load or store per accepted operation against data RAM,
// with lane alignment, a bounded response wait and a one-cycle load writeback beat.
//
// state      | meaning
// IDLE       | op_ready high, waiting for an operation
// LOAD_WAIT  | rd_ram_en held until rd_ram_valid or timeout
// STORE_WAIT | wr_ram_en held until wr_ram_ack or timeout
// RESP       | wb_valid beat for the captured load data
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset_n,
  mem_access_stage_if.slave  bus
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  mem_state_t  state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [4:0]  rd_q;
  logic        op_ready_q;
  logic        rd_en_q;
  logic        wr_en_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;
  logic        timeout_q;

  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [31:0] ld_data;

  // Fed from the latched operation so RAM data/mask hold steady while enabled.
  mem_lane_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (unsigned_q),
    .st_data_i  (sdata_q),
    .rd_data_i  (bus.rd_ram_data),
    .wr_data_o  (wr_data),
    .wr_mask_o  (wr_mask),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      sdata_q      <= '0;
      rd_q         <= '0;
      op_ready_q   <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.op_valid && op_ready_q) begin
            size_q     <= bus.op_size;
            unsigned_q <= bus.op_unsigned;
            addr_q     <= bus.op_addr;
            sdata_q    <= bus.op_store_data;
            rd_q       <= bus.op_rd;
            cnt_q      <= '0;
            if (is_misaligned(bus.op_size, bus.op_addr[1:0])) begin
              misaligned_q <= 1'b1;
            end else if (bus.op_is_store) begin
              state_q    <= STORE_WAIT;
              wr_en_q    <= 1'b1;
              op_ready_q <= 1'b0;
            end else begin
              state_q    <= LOAD_WAIT;
              rd_en_q    <= 1'b1;
              op_ready_q <= 1'b0;
            end
          end
        end
        LOAD_WAIT: begin
          // A response in the same cycle the limit is reached still completes.
          if (bus.rd_ram_valid) begin
            rd_en_q    <= 1'b0;
            wb_data_q  <= ld_data;
            wb_rd_q    <= rd_q;
            wb_valid_q <= (rd_q != 5'd0);
            state_q    <= RESP;
          end else if (cnt_q == TMO_LIMIT) begin
            rd_en_q    <= 1'b0;
            timeout_q  <= 1'b1;
            op_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        STORE_WAIT: begin
          if (bus.wr_ram_ack) begin
            wr_en_q    <= 1'b0;
            op_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else if (cnt_q == TMO_LIMIT) begin
            wr_en_q    <= 1'b0;
            timeout_q  <= 1'b1;
            op_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          op_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          rd_en_q    <= 1'b0;
          wr_en_q    <= 1'b0;
          op_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready    = op_ready_q;
  assign bus.rd_ram_en   = rd_en_q;
  assign bus.rd_ram_addr = rd_en_q ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.wr_ram_en   = wr_en_q;
  assign bus.wr_ram_addr = wr_en_q ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.wr_ram_data = wr_en_q ? wr_data : 32'd0;
  assign bus.wr_ram_mask = wr_en_q ? wr_mask : 4'd0;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle response limit;
// expected values are hand-computed from the intended lane and timing behaviour.
module tb_mem_access_stage;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd);
    bus.op_valid      = 1'b1;
    bus.op_is_store   = st;
    bus.op_size       = sz;
    bus.op_unsigned   = uns;
    bus.op_addr       = addr;
    bus.op_store_data = sd;
    bus.op_rd         = rd;
  endtask

  // Offer a load, accept it, answer on the first wait cycle, return after RESP.
  task automatic load_now(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] ram, input logic [31:0] exp_data,
                          input logic exp_wb);
    offer(1'b0, sz, uns, addr, 32'd0, rd);
    tick();
    bus.op_valid = 1'b0;
    chk({tag, "_rd_en"}, 32'(bus.rd_ram_en), 32'd1);
    chk({tag, "_rd_addr"}, bus.rd_ram_addr, {addr[31:2], 2'b00});
    bus.rd_ram_valid = 1'b1;
    bus.rd_ram_data  = ram;
    tick();
    bus.rd_ram_valid = 1'b0;
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'(exp_wb));
    if (exp_wb) begin
      chk({tag, "_wb_data"}, bus.wb_data, exp_data);
      chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(rd));
    end
    chk({tag, "_rd_en_drop"}, 32'(bus.rd_ram_en), 32'd0);
    chk({tag, "_busy"}, 32'(bus.op_ready), 32'd0);
    tick();
    chk({tag, "_wb_once"}, 32'(bus.wb_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
  endtask

  // Store with immediate ack.
  task automatic store_now(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] exp_data,
                           input logic [3:0] exp_mask);
    offer(1'b1, sz, 1'b0, addr, sd, 5'd1);
    tick();
    bus.op_valid = 1'b0;
    chk({tag, "_wr_en"}, 32'(bus.wr_ram_en), 32'd1);
    chk({tag, "_wr_addr"}, bus.wr_ram_addr, {addr[31:2], 2'b00});
    chk({tag, "_wr_data"}, bus.wr_ram_data, exp_data);
    chk({tag, "_wr_mask"}, 32'(bus.wr_ram_mask), 32'(exp_mask));
    bus.wr_ram_ack = 1'b1;
    tick();
    bus.wr_ram_ack = 1'b0;
    chk({tag, "_wr_drop"}, 32'(bus.wr_ram_en), 32'd0);
    chk({tag, "_ready"}, 32'(bus.op_ready), 32'd1);
    chk({tag, "_no_wb"}, 32'(bus.wb_valid), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_is_store = 1'b0; bus.op_size = 2'd0; bus.op_unsigned = 1'b0;
    bus.op_addr = 32'd0; bus.op_store_data = 32'd0; bus.op_rd = 5'd0;
    bus.rd_ram_data = 32'd0; bus.rd_ram_valid = 1'b0; bus.wr_ram_ack = 1'b0;
    #12;
    chk("rst_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_rd_en", 32'(bus.rd_ram_en), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_ram_en), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_err", {30'd0, bus.misaligned, bus.timeout}, 32'd0);
    #10 reset_n = 1'b1;
    tick();

    load_now("lb_signed", 2'b00, 1'b0, 32'h0000_0103, 5'd5, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1);
    load_now("lhu", 2'b01, 1'b1, 32'h0000_0022, 5'd7, 32'hBEEF_0001, 32'h0000_BEEF, 1'b1);
    load_now("lh_rd0", 2'b01, 1'b1, 32'h0000_0022, 5'd0, 32'hBEEF_0001, 32'h0, 1'b0);
    load_now("lh_signed", 2'b01, 1'b0, 32'h0000_0010, 5'd2, 32'h1234_8001, 32'hFFFF_8001, 1'b1);
    load_now("lw", 2'b10, 1'b0, 32'h0000_0204, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);

    // Byte store held three cycles before ack.
    offer(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h1234_56A5, 5'd0);
    tick();
    bus.op_valid = 1'b0;
    chk("sb_wr_addr", bus.wr_ram_addr, 32'h0000_0040);
    chk("sb_wr_data", bus.wr_ram_data, 32'hA5A5_A5A5);
    chk("sb_wr_mask", 32'(bus.wr_ram_mask), 32'h2);
    chk("sb_busy", 32'(bus.op_ready), 32'd0);
    tick();
    chk("sb_hold_en", 32'(bus.wr_ram_en), 32'd1);
    chk("sb_hold_mask", 32'(bus.wr_ram_mask), 32'h2);
    tick();
    chk("sb_hold_data", bus.wr_ram_data, 32'hA5A5_A5A5);
    bus.wr_ram_ack = 1'b1;
    tick();
    bus.wr_ram_ack = 1'b0;
    chk("sb_ready", 32'(bus.op_ready), 32'd1);
    chk("sb_wr_drop", 32'(bus.wr_ram_en), 32'd0);
    chk("sb_no_wb", 32'(bus.wb_valid), 32'd0);

    store_now("sh", 2'b01, 32'h0000_0012, 32'hDEAD_BEEF, 32'hBEEF_BEEF, 4'b1100);
    store_now("sw", 2'b10, 32'h0000_0008, 32'h0123_4567, 32'h0123_4567, 4'b1111);

    // Misaligned word load, then a good load offered straight away.
    offer(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0, 5'd3);
    tick();
    chk("mis_pulse", 32'(bus.misaligned), 32'd1);
    chk("mis_no_req", 32'(bus.rd_ram_en), 32'd0);
    chk("mis_ready", 32'(bus.op_ready), 32'd1);
    offer(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'd0, 5'd3);
    tick();
    bus.op_valid = 1'b0;
    chk("mis_pulse_end", 32'(bus.misaligned), 32'd0);
    chk("b2b_rd_en", 32'(bus.rd_ram_en), 32'd1);
    chk("b2b_rd_addr", bus.rd_ram_addr, 32'h0000_0100);
    bus.rd_ram_valid = 1'b1;
    bus.rd_ram_data  = 32'h80FF_1234;
    tick();
    bus.rd_ram_valid = 1'b0;
    chk("b2b_wb_data", bus.wb_data, 32'h0000_0012);
    chk("b2b_wb_valid", 32'(bus.wb_valid), 32'd1);
    tick();

    offer(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 5'd3);
    tick();
    chk("mis_size11", 32'(bus.misaligned), 32'd1);
    offer(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'hFFFF, 5'd0);
    tick();
    bus.op_valid = 1'b0;
    chk("mis_half", 32'(bus.misaligned), 32'd1);
    chk("mis_half_no_wr", 32'(bus.wr_ram_en), 32'd0);
    tick();
    chk("mis_clear", 32'(bus.misaligned), 32'd0);

    // No response: five wait cycles (count 0..4), then timeout.
    offer(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0, 5'd9);
    tick();
    bus.op_valid = 1'b0;
    repeat (4) tick();
    chk("tmo_still_wait", 32'(bus.rd_ram_en), 32'd1);
    chk("tmo_not_yet", 32'(bus.timeout), 32'd0);
    tick();
    chk("tmo_pulse", 32'(bus.timeout), 32'd1);
    chk("tmo_en_drop", 32'(bus.rd_ram_en), 32'd0);
    chk("tmo_ready", 32'(bus.op_ready), 32'd1);
    chk("tmo_no_wb", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("tmo_pulse_end", 32'(bus.timeout), 32'd0);

    // Response on the limit cycle completes normally.
    offer(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd10);
    tick();
    bus.op_valid = 1'b0;
    repeat (4) tick();
    bus.rd_ram_valid = 1'b1;
    bus.rd_ram_data  = 32'hCAFE_F00D;
    tick();
    bus.rd_ram_valid = 1'b0;
    chk("lim_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("lim_wb_data", bus.wb_data, 32'hCAFE_F00D);
    chk("lim_no_tmo", 32'(bus.timeout), 32'd0);
    tick();
    chk("lim_no_tmo2", 32'(bus.timeout), 32'd0);
    chk("lim_ready", 32'(bus.op_ready), 32'd1);

    // Store timeout.
    offer(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h5555_AAAA, 5'd0);
    tick();
    bus.op_valid = 1'b0;
    repeat (5) tick();
    chk("stmo_pulse", 32'(bus.timeout), 32'd1);
    chk("stmo_en_drop", 32'(bus.wr_ram_en), 32'd0);

    // Reset during LOAD_WAIT, then a stray response.
    offer(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'd0, 5'd4);
    tick();
    bus.op_valid = 1'b0;
    chk("rstmid_rd_en", 32'(bus.rd_ram_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_drop", 32'(bus.rd_ram_en), 32'd0);
    #3 reset_n = 1'b1;
    chk("rstmid_ready", 32'(bus.op_ready), 32'd1);
    bus.rd_ram_valid = 1'b1;
    bus.rd_ram_data  = 32'h1111_2222;
    bus.wr_ram_ack   = 1'b1;
    tick();
    bus.rd_ram_valid = 1'b0;
    bus.wr_ram_ack   = 1'b0;
    chk("stray_no_wb", 32'(bus.wb_valid), 32'd0);
    chk("stray_no_en", 32'(bus.rd_ram_en), 32'd0);
    chk("stray_ready", 32'(bus.op_ready), 32'd1);
    tick();
    chk("stray_no_err", {30'd0, bus.misaligned, bus.timeout}, 32'd0);
    chk("stray_no_wb2", 32'(bus.wb_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
